// File: rtl/top_fifo_uart.sv
// top_fifo_uart: byte FIFO driven over an 8N1 UART (0x30 WRITE, 0x31 READ, 0x32 STATUS).
// Define WRITE_ACK_EN to answer each WRITE data byte with 0x06 (stored) or 0x15 (dropped).
module top_fifo_uart #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600,
    parameter int DEPTH    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx,
    output logic                   tx,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int BIT_CLKS  = CLK_FREQ / BAUD;
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam int CNT_W     = $clog2(BIT_CLKS + 1);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_FW    = $clog2(DEPTH) + 1;

    localparam logic [7:0] CMD_WRITE  = 8'h30;
    localparam logic [7:0] CMD_READ   = 8'h31;
    localparam logic [7:0] CMD_STATUS = 8'h32;
    localparam logic [7:0] RESP_EMPTY = 8'hEE;
`ifdef WRITE_ACK_EN
    localparam logic [7:0] RESP_ACK   = 8'h06;
    localparam logic [7:0] RESP_NAK   = 8'h15;
`endif

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {IDLE, WAIT_DATA, PUSH, POP, STATUS, SEND, WAIT_TX} state_t;

    rx_state_t        rx_state, rx_next;
    logic             rx_meta, rx_sync, rx_prev;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift, rx_byte;
    logic             rx_valid, rx_fall, rx_half_tick, rx_bit_tick;

    logic             tx_busy, tx_start;
    logic [8:0]       tx_shift;
    logic [3:0]       tx_left;
    logic [CNT_W-1:0] tx_cnt;

    state_t           state, state_next;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, empty;
    logic [3:0]       status_count;
    logic [7:0]       hold_byte, data_byte, cmd_byte, resp_byte, resp_next;
    logic             hold_valid, direct_ok, cmd_valid, do_push, do_pop, resp_load;

    assign rx_fall      = rx_prev & ~rx_sync;
    assign rx_half_tick = (rx_cnt == CNT_W'(HALF_CLKS - 1));
    assign rx_bit_tick  = (rx_cnt == CNT_W'(BIT_CLKS - 1));

    // Synchronizer resets low so a line that is already low at release is never taken as a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b0;
            rx_sync <= 1'b0;
            rx_prev <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_half_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_bit_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_bit_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_state <= rx_next;
            rx_valid <= 1'b0;
            if (rx_next != rx_state || (rx_state == RX_DATA && rx_bit_tick))
                rx_cnt <= '0;
            else
                rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == RX_START)
                rx_bit <= '0;
            if (rx_state == RX_DATA && rx_bit_tick) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bit   <= rx_bit + 1'b1;
            end
            if (rx_state == RX_STOP && rx_bit_tick && rx_sync) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
            end
        end
    end

    // Start bit goes out on the load edge; tx_shift then holds the data bits and the stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_shift <= '1;
            tx_left  <= '0;
            tx_cnt   <= '0;
        end else if (!tx_busy) begin
            tx <= 1'b1;
            if (tx_start) begin
                tx       <= 1'b0;
                tx_busy  <= 1'b1;
                tx_shift <= {1'b1, resp_byte};
                tx_left  <= 4'd9;
                tx_cnt   <= '0;
            end
        end else if (tx_cnt == CNT_W'(BIT_CLKS - 1)) begin
            tx_cnt <= '0;
            if (tx_left == 4'd0) begin
                tx_busy <= 1'b0;
                tx      <= 1'b1;
            end else begin
                tx       <= tx_shift[0];
                tx_shift <= {1'b1, tx_shift[8:1]};
                tx_left  <= tx_left - 1'b1;
            end
        end else begin
            tx_cnt <= tx_cnt + 1'b1;
        end
    end

    assign full         = (fifo_count == CNT_FW'(DEPTH));
    assign empty        = (fifo_count == '0);
    assign status_count = 4'(fifo_count);

    // A byte is taken directly only when the decoder can use it and nothing older is parked.
    assign direct_ok = (state == IDLE || state == WAIT_DATA) && !hold_valid;
    assign cmd_valid = (state == IDLE || state == WAIT_DATA) && (hold_valid || rx_valid);
    assign cmd_byte  = hold_valid ? hold_byte : rx_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_byte  <= '0;
        end else if (rx_valid && !direct_ok) begin
            hold_valid <= 1'b1;
            hold_byte  <= rx_byte;
        end else if (cmd_valid) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        resp_load  = 1'b0;
        resp_next  = 8'h00;
        tx_start   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    case (cmd_byte)
                        CMD_WRITE:  state_next = WAIT_DATA;
                        CMD_READ:   state_next = POP;
                        CMD_STATUS: state_next = STATUS;
                        default:    state_next = IDLE;
                    endcase
                end
            end
            WAIT_DATA: if (cmd_valid) state_next = PUSH;
            PUSH: begin
                do_push = !full;
`ifdef WRITE_ACK_EN
                resp_load  = 1'b1;
                resp_next  = full ? RESP_NAK : RESP_ACK;
                state_next = SEND;
`else
                state_next = IDLE;
`endif
            end
            POP: begin
                do_pop     = !empty;
                resp_load  = 1'b1;
                resp_next  = empty ? RESP_EMPTY : mem[rd_ptr];
                state_next = SEND;
            end
            STATUS: begin
                resp_load  = 1'b1;
                resp_next  = {full, empty, 2'b00, status_count};
                state_next = SEND;
            end
            SEND: begin
                tx_start   = 1'b1;
                state_next = WAIT_TX;
            end
            WAIT_TX: if (!tx_busy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            data_byte  <= '0;
            resp_byte  <= '0;
        end else begin
            if (state == WAIT_DATA && cmd_valid)
                data_byte <= cmd_byte;
            if (resp_load)
                resp_byte <= resp_next;
            if (do_push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                fifo_count <= fifo_count + 1'b1;
            end else if (do_pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    // Storage keeps stale contents across reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= data_byte;
    end
endmodule

// File: tb/tb_top_fifo_uart.sv
// Bench for top_fifo_uart: table of command vectors, hand-written corner sequences and
// random commands compared against a queue-based model of the command protocol.
`timescale 1ns/1ps
module tb_top_fifo_uart;
    localparam int CLK_FREQ = 160_000;
    localparam int BAUD     = 10_000;
    localparam int DEPTH    = 8;
    localparam int BIT      = CLK_FREQ / BAUD;
    localparam int HALF     = BIT / 2;
`ifdef WRITE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    typedef struct {
        logic [7:0] din;
        int         n_resp;
        logic [7:0] resp;
        int         count;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       tx;
    logic [3:0] fifo_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_stop_cyc = 0;
    int last_tx_start = 0;
    int tx_q[$];
    int exp_q[$];
    logic [7:0] m_fifo[$];
    bit m_wait = 1'b0;
    vec_t vecs[16];

    top_fifo_uart #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Decode every frame on tx; a frame with a bad start or stop bit is recorded as -1.
    initial begin : tx_monitor
        logic [7:0] data;
        bit ok;
        forever begin
            @(negedge tx);
            if (rst_n) begin
                last_tx_start = cyc;
                repeat (HALF) @(negedge clk);
                ok = (tx == 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(negedge clk);
                    data[i] = tx;
                end
                repeat (BIT) @(negedge clk);
                ok = ok && (tx == 1'b1);
                tx_q.push_back(ok ? int'(data) : -1);
            end
        end
    end

    initial begin : watchdog
        repeat (90000) @(posedge clk);
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit bad_stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        last_stop_cyc = cyc;
        rx = !bad_stop;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        if (bad_stop) repeat (BIT) @(negedge clk);
    endtask

    task automatic wait_response(input int frames);
        repeat (frames * 11 * BIT) @(negedge clk);
    endtask

    task automatic check_resp(input string name, input int exp_n, input int exp_byte);
        checkOutput($sformatf("%s frames", name), tx_q.size(), exp_n);
        if (exp_n > 0 && tx_q.size() > 0)
            checkOutput($sformatf("%s byte", name), tx_q[0], exp_byte);
        tx_q.delete();
    endtask

    task automatic send_write(input logic [7:0] b, input int exp_resp);
        applyStimulus(8'h30, 1'b0);
        applyStimulus(b, 1'b0);
        wait_response(1);
        check_resp($sformatf("write %0h", b), int'(ACK), exp_resp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Reference model: protocol rules on a plain queue, responses appended to exp_q.
    task automatic model_byte(input logic [7:0] b);
        if (m_wait) begin
            m_wait = 1'b0;
            if (m_fifo.size() < DEPTH) begin
                m_fifo.push_back(b);
                if (ACK) exp_q.push_back(8'h06);
            end else if (ACK) begin
                exp_q.push_back(8'h15);
            end
        end else begin
            case (b)
                8'h30: m_wait = 1'b1;
                8'h31: if (m_fifo.size() > 0) exp_q.push_back(int'(m_fifo.pop_front()));
                       else exp_q.push_back(8'hEE);
                8'h32: exp_q.push_back(int'({m_fifo.size() == DEPTH, m_fifo.size() == 0,
                                              2'b00, 4'(m_fifo.size())}));
                default: ;
            endcase
        end
    endtask

    initial begin
        int lat;
        int op;
        bit timeout;
        logic [7:0] b;

        vecs[0]  = '{8'h30, 0,         8'h00, 0};
        vecs[1]  = '{8'hAA, int'(ACK), 8'h06, 1};
        vecs[2]  = '{8'h31, 1,         8'hAA, 0};
        vecs[3]  = '{8'h31, 1,         8'hEE, 0};
        vecs[4]  = '{8'h32, 1,         8'h40, 0};
        vecs[5]  = '{8'hBB, 0,         8'h00, 0};
        vecs[6]  = '{8'h30, 0,         8'h00, 0};
        vecs[7]  = '{8'h31, int'(ACK), 8'h06, 1};
        vecs[8]  = '{8'h30, 0,         8'h00, 1};
        vecs[9]  = '{8'h32, int'(ACK), 8'h06, 2};
        vecs[10] = '{8'h30, 0,         8'h00, 2};
        vecs[11] = '{8'h33, int'(ACK), 8'h06, 3};
        vecs[12] = '{8'h32, 1,         8'h03, 3};
        vecs[13] = '{8'h31, 1,         8'h31, 2};
        vecs[14] = '{8'h31, 1,         8'h32, 1};
        vecs[15] = '{8'h31, 1,         8'h33, 0};

        repeat (3) @(negedge clk);
        checkOutput("reset tx", int'(tx), 1);
        checkOutput("reset count", int'(fifo_count), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] table vectors");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].din, 1'b0);
            wait_response(1);
            if (vecs[i].n_resp > 0 && tx_q.size() > 0) begin
                lat = last_tx_start - last_stop_cyc;
                checkOutput($sformatf("vec%0d latency in range (%0d)", i, lat),
                            int'(lat >= HALF && lat <= HALF + 12), 1);
            end
            check_resp($sformatf("vec%0d", i), vecs[i].n_resp, vecs[i].resp);
            checkOutput($sformatf("vec%0d count", i), int'(fifo_count), vecs[i].count);
        end

        $display("[TB] fill, overflow, drain");
        for (int i = 1; i <= 8; i++) send_write(8'(i), 8'h06);
        checkOutput("full count", int'(fifo_count), 8);
        applyStimulus(8'h32, 1'b0);
        wait_response(1);
        check_resp("status full", 1, 8'h88);
        send_write(8'h09, 8'h15);
        checkOutput("overflow count", int'(fifo_count), 8);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(8'h31, 1'b0);
            wait_response(1);
            check_resp($sformatf("drain %0d", i), 1, i);
        end
        checkOutput("drained count", int'(fifo_count), 0);

        $display("[TB] bad stop bit");
        applyStimulus(8'h30, 1'b1);
        applyStimulus(8'h31, 1'b0);
        wait_response(1);
        check_resp("after bad stop", 1, 8'hEE);
        checkOutput("after bad stop count", int'(fifo_count), 0);

        $display("[TB] commands queued behind a response");
        send_write(8'h44, 8'h06);
        send_write(8'h45, 8'h06);
        applyStimulus(8'h31, 1'b0);
        applyStimulus(8'h31, 1'b0);
        applyStimulus(8'h32, 1'b0);
        wait_response(3);
        checkOutput("queued frames", tx_q.size(), 3);
        if (tx_q.size() == 3) begin
            checkOutput("queued byte0", tx_q[0], 8'h44);
            checkOutput("queued byte1", tx_q[1], 8'h45);
            checkOutput("queued byte2", tx_q[2], 8'h40);
        end
        tx_q.delete();

        $display("[TB] reset during transmit");
        send_write(8'h70, 8'h06);
        send_write(8'h71, 8'h06);
        applyStimulus(8'h31, 1'b0);
        timeout = 1'b1;
        for (int k = 0; k < 4 * BIT; k++) begin
            @(negedge clk);
            if (tx == 1'b0) begin
                timeout = 1'b0;
                break;
            end
        end
        checkOutput("tx start seen", int'(timeout), 0);
        repeat (2 * BIT) @(negedge clk);
        checkOutput("mid-tx line low", int'(tx), 0);
        checkOutput("mid-tx count", int'(fifo_count), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset mid-tx tx", int'(tx), 1);
        checkOutput("reset mid-tx count", int'(fifo_count), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * BIT) @(negedge clk);
        tx_q.delete();

        $display("[TB] reset during receive");
        send_write(8'h5A, 8'h06);
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
        rx = 1'b0;
        repeat (HALF) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("reset mid-rx count", int'(fifo_count), 0);
        checkOutput("reset mid-rx tx", int'(tx), 1);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        applyStimulus(8'h31, 1'b0);
        wait_response(1);
        check_resp("after rx reset", 1, 8'hEE);

        $display("[TB] random commands");
        do_reset();
        m_fifo.delete();
        exp_q.delete();
        tx_q.delete();
        m_wait = 1'b0;
        for (int i = 0; i < 30; i++) begin
            op = $urandom_range(0, 5);
            if (op <= 2) begin
                b = 8'($urandom_range(0, 255));
                applyStimulus(8'h30, 1'b0);
                applyStimulus(b, 1'b0);
                model_byte(8'h30);
                model_byte(b);
            end else if (op == 3) begin
                applyStimulus(8'h31, 1'b0);
                model_byte(8'h31);
            end else if (op == 4) begin
                applyStimulus(8'h32, 1'b0);
                model_byte(8'h32);
            end else begin
                b = 8'($urandom_range(0, 255));
                if (b >= 8'h30 && b <= 8'h32) b = 8'hC3;
                applyStimulus(b, 1'b0);
                model_byte(b);
            end
            wait_response(1);
            checkOutput($sformatf("rand%0d frames", i), tx_q.size(), exp_q.size());
            for (int k = 0; k < exp_q.size() && k < tx_q.size(); k++)
                checkOutput($sformatf("rand%0d byte%0d", i, k), tx_q[k], exp_q[k]);
            checkOutput($sformatf("rand%0d count", i), int'(fifo_count), m_fifo.size());
            tx_q.delete();
            exp_q.delete();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
